// File: rtl/seg7_scan_decoder.sv
// Scanned 7-segment display decoder: frame assembly, debounce, publish.
// Optional dp capture enabled by defining SEG7_DP_CAPTURE_EN.
module seg7_scan_decoder #(
  parameter int STABLE_FRAMES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  Segment,
  input  logic [3:0]  DigitSel,
  input  logic        SegStrobe,
  input  logic        Ready,
  input  logic        ErrClr,
  output logic [15:0] BCD_Out,
  output logic [3:0]  DP_Out,
  output logic        Valid,
  output logic [2:0]  ErrFlag
);

  localparam logic [3:0] STABLE = 4'(STABLE_FRAMES);

  logic [3:0]  seen;
  logic [15:0] slot_nib;
  logic [3:0]  slot_dp;
  logic [15:0] cand_nib;
  logic [3:0]  cand_dp;
  logic [3:0]  mcnt;
  logic [15:0] pub_nib;
  logic [3:0]  pub_dp;
  logic        pub_once;

  logic [3:0]  pat_nib;
  logic        pat_bad;
  logic        dp_in;
  logic        sel_ok;
  logic        wr;
  logic        complete;
  logic [15:0] frm_nib;
  logic [3:0]  frm_dp;
  logic        same;
  logic        changed;
  logic [3:0]  mcnt_nx;
  logic        pub_req;
  logic        load;
  logic        ovr;
  logic [2:0]  err_set;

`ifdef SEG7_DP_CAPTURE_EN
  assign dp_in = Segment[7];
`else
  assign dp_in = Segment[7] & 1'b0;
`endif

  // exact-match segment pattern to nibble
  always_comb begin
    pat_nib = 4'hF;
    pat_bad = 1'b0;
    unique case (Segment[6:0])
      7'h7E: pat_nib = 4'h0;
      7'h30: pat_nib = 4'h1;
      7'h6D: pat_nib = 4'h2;
      7'h79: pat_nib = 4'h3;
      7'h33: pat_nib = 4'h4;
      7'h5B: pat_nib = 4'h5;
      7'h5F: pat_nib = 4'h6;
      7'h70: pat_nib = 4'h7;
      7'h7F: pat_nib = 4'h8;
      7'h7B: pat_nib = 4'h9;
      7'h00: pat_nib = 4'hA;
      default: pat_bad = 1'b1;
    endcase
  end

  assign sel_ok   = (DigitSel != 4'h0) &&
                    ((DigitSel & (DigitSel - 4'h1)) == 4'h0);
  assign wr       = SegStrobe && sel_ok;
  assign complete = wr && (&(seen | DigitSel));

  // frame contents as they stand after this strobe
  always_comb begin
    frm_nib = slot_nib;
    frm_dp  = slot_dp;
    for (int i = 0; i < 4; i++) begin
      if (DigitSel[i]) begin
        frm_nib[i*4 +: 4] = pat_nib;
        frm_dp[i]         = dp_in;
      end
    end
  end

  assign same    = {frm_dp, frm_nib} == {cand_dp, cand_nib};
  assign changed = ({frm_dp, frm_nib} != {pub_dp, pub_nib}) || !pub_once;
  assign mcnt_nx = !same ? 4'd1 :
                   (mcnt == 4'hF) ? 4'hF : mcnt + 4'd1;
  assign pub_req = complete && (mcnt_nx == STABLE) && changed;
  assign load    = pub_req && (!Valid || Ready);
  assign ovr     = pub_req && Valid && !Ready;
  assign err_set = {ovr, SegStrobe && !sel_ok, SegStrobe && pat_bad};

  // frame slots and seen bits; seen clears as the frame completes
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      seen     <= 4'h0;
      slot_nib <= 16'h0;
      slot_dp  <= 4'h0;
    end else if (wr) begin
      seen     <= complete ? 4'h0 : (seen | DigitSel);
      slot_nib <= frm_nib;
      slot_dp  <= frm_dp;
    end
  end

  // candidate frame and its consecutive-match count
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cand_nib <= 16'h0;
      cand_dp  <= 4'h0;
      mcnt     <= 4'h0;
    end else if (complete) begin
      cand_nib <= frm_nib;
      cand_dp  <= frm_dp;
      mcnt     <= mcnt_nx;
    end
  end

  // publish register and valid/ready handshake
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      BCD_Out  <= 16'h0;
      DP_Out   <= 4'h0;
      Valid    <= 1'b0;
      pub_nib  <= 16'h0;
      pub_dp   <= 4'h0;
      pub_once <= 1'b0;
    end else if (load) begin
      BCD_Out  <= frm_nib;
      DP_Out   <= frm_dp;
      Valid    <= 1'b1;
      pub_nib  <= frm_nib;
      pub_dp   <= frm_dp;
      pub_once <= 1'b1;
    end else if (Valid && Ready) begin
      Valid    <= 1'b0;
    end
  end

  // sticky error flags; a new event beats a clear
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ErrFlag <= 3'b000;
    end else begin
      ErrFlag <= (ErrClr ? 3'b000 : ErrFlag) | err_set;
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with a publish scoreboard.
// Expected dp results follow SEG7_DP_CAPTURE_EN.
module tb_seg7_scan_decoder;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [7:0]  Segment = 8'h00;
  logic [3:0]  DigitSel = 4'h0;
  logic        SegStrobe = 1'b0;
  logic        Ready = 1'b0;
  logic        ErrClr = 1'b0;
  logic [15:0] BCD_Out;
  logic [3:0]  DP_Out;
  logic        Valid;
  logic [2:0]  ErrFlag;

  int n_asrt = 0;
  int n_fail = 0;
  logic [19:0] exp_q[$];

  seg7_scan_decoder #(.STABLE_FRAMES(2)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .Segment(Segment),
    .DigitSel(DigitSel),
    .SegStrobe(SegStrobe),
    .Ready(Ready),
    .ErrClr(ErrClr),
    .BCD_Out(BCD_Out),
    .DP_Out(DP_Out),
    .Valid(Valid),
    .ErrFlag(ErrFlag)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 7'h7E;
      4'h1: enc = 7'h30;
      4'h2: enc = 7'h6D;
      4'h3: enc = 7'h79;
      4'h4: enc = 7'h33;
      4'h5: enc = 7'h5B;
      4'h6: enc = 7'h5F;
      4'h7: enc = 7'h70;
      4'h8: enc = 7'h7F;
      4'h9: enc = 7'h7B;
      4'hA: enc = 7'h00;
      default: enc = 7'h55;
    endcase
  endfunction

  function automatic logic [3:0] dpx(input logic [3:0] dp);
`ifdef SEG7_DP_CAPTURE_EN
    dpx = dp;
`else
    dpx = 4'h0 & dp;
`endif
  endfunction

  task automatic strobe(input logic [7:0] seg, input logic [3:0] sel,
                        input logic clr);
    @(negedge CLK);
    Segment   = seg;
    DigitSel  = sel;
    SegStrobe = 1'b1;
    ErrClr    = clr;
    @(negedge CLK);
    SegStrobe = 1'b0;
    ErrClr    = 1'b0;
  endtask

  task automatic frame(input logic [15:0] v, input logic [3:0] dp);
    for (int d = 3; d >= 0; d--) begin
      strobe({dp[d], enc(v[d*4 +: 4])}, 4'(1 << d), 1'b0);
    end
  endtask

  task automatic expect_pub(input string tag);
    logic [19:0] e;
    chk({tag, "_valid"}, 32'(Valid), 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_bcd"}, 32'(BCD_Out), 32'(e[15:0]));
      chk({tag, "_dp"}, 32'(DP_Out), 32'(e[19:16]));
    end
  endtask

  task automatic accept();
    @(negedge CLK);
    Ready = 1'b1;
    @(negedge CLK);
    Ready = 1'b0;
  endtask

  task automatic clear_err();
    @(negedge CLK);
    ErrClr = 1'b1;
    @(negedge CLK);
    ErrClr = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    chk("rst_bcd", 32'(BCD_Out), 32'h0);
    chk("rst_dp", 32'(DP_Out), 32'h0);
    chk("rst_valid", 32'(Valid), 32'h0);
    chk("rst_err", 32'(ErrFlag), 32'h0);

    frame(16'h3210, 4'h0);
    chk("f1_novalid", 32'(Valid), 32'h0);
    exp_q.push_back({4'h0, 16'h3210});
    frame(16'h3210, 4'h0);
    expect_pub("f2");

    frame(16'h3210, 4'h0);
    chk("f3_valid", 32'(Valid), 32'h1);
    chk("f3_bcd", 32'(BCD_Out), 32'h3210);
    frame(16'h4567, 4'h0);
    chk("ch1_err", 32'(ErrFlag), 32'h0);
    frame(16'h4567, 4'h0);
    chk("ovr_err", 32'(ErrFlag), 32'h4);
    chk("ovr_bcd", 32'(BCD_Out), 32'h3210);
    chk("ovr_valid", 32'(Valid), 32'h1);
    accept();
    chk("acc_valid", 32'(Valid), 32'h0);
    chk("acc_bcd", 32'(BCD_Out), 32'h3210);
    clear_err();
    chk("clr_err", 32'(ErrFlag), 32'h0);

    strobe({1'b0, enc(4'h9)}, 4'b1000, 1'b0);
    strobe({1'b0, enc(4'h8)}, 4'b0100, 1'b0);
    strobe({1'b0, enc(4'h1)}, 4'b0110, 1'b0);
    chk("badsel_err", 32'(ErrFlag), 32'h2);
    strobe({1'b0, enc(4'h7)}, 4'b0010, 1'b0);
    strobe({1'b0, enc(4'h6)}, 4'b0001, 1'b0);
    chk("badsel_f1", 32'(Valid), 32'h0);
    exp_q.push_back({4'h0, 16'h9876});
    frame(16'h9876, 4'h0);
    expect_pub("badsel_f2");
    accept();
    chk("acc2_valid", 32'(Valid), 32'h0);
    clear_err();

    frame(16'hAAF0, 4'h0);
    chk("inv_err", 32'(ErrFlag), 32'h1);
    chk("inv_novalid", 32'(Valid), 32'h0);
    exp_q.push_back({4'h0, 16'hAAF0});
    frame(16'hAAF0, 4'h0);
    expect_pub("inv_f2");
    clear_err();
    chk("clr2_err", 32'(ErrFlag), 32'h0);
    strobe(8'h00, 4'b1000, 1'b0);
    chk("blank_err", 32'(ErrFlag), 32'h0);
    strobe(8'h55, 4'b0100, 1'b1);
    chk("clr_vs_evt", 32'(ErrFlag), 32'h1);

    strobe({1'b0, enc(4'h5)}, 4'b0010, 1'b0);
    strobe({1'b0, enc(4'h5)}, 4'b0001, 1'b0);
    chk("pre_rst_valid", 32'(Valid), 32'h1);
    strobe({1'b0, enc(4'h5)}, 4'b0010, 1'b0);
    strobe({1'b0, enc(4'h5)}, 4'b0001, 1'b0);
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    chk("mid_rst_valid", 32'(Valid), 32'h0);
    chk("mid_rst_bcd", 32'(BCD_Out), 32'h0);
    chk("mid_rst_err", 32'(ErrFlag), 32'h0);
    frame(16'h1234, 4'b0100);
    chk("pr_f1_novalid", 32'(Valid), 32'h0);
    exp_q.push_back({dpx(4'b0100), 16'h1234});
    frame(16'h1234, 4'b0100);
    expect_pub("pr_f2");
    accept();
    chk("acc3_valid", 32'(Valid), 32'h0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
